mac_rx_read_ctrl: RTL and testbench

MAC_RX_READ_CTRL -- requirements
Module: mac_rx_read_ctrl

---
 rtl/mac_rx_read_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mac_rx_read_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_read_ctrl.sv
// MAC RX FIFO reader: pulls words from the MAC FIFO, frames them onto an
// AXI-stream master, truncates oversize/broken frames and keeps frame statistics.
module mac_rx_read_ctrl #(
    parameter int MAX_WORDS = 384
) (
    input  logic        mac_clk_i,
    input  logic        mac_rst_i,
    input  logic [31:0] mac_rxd_i,
    input  logic [1:0]  mac_ben_i,
    input  logic        mac_rxda_i,
    input  logic        mac_rxsop_i,
    input  logic        mac_rxeop_i,
    input  logic        mac_rxdv_i,
    output logic        mac_rxrqrd_o,
    output logic [31:0] m_tdata_o,
    output logic [3:0]  m_tkeep_o,
    output logic        m_tvalid_o,
    output logic        m_tlast_o,
    output logic        m_tuser_o,
    input  logic        m_tready_i,
    output logic [15:0] len_o,
    output logic        len_vld_o,
    output logic [15:0] frm_cnt_o,
    output logic [15:0] drop_cnt_o
);

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t      state;
    logic [31:0] data_mem [2];
    logic [3:0]  keep_mem [2];
    logic        last_mem [2];
    logic        user_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  entries;
    logic        rd_pend_p0;
    logic [15:0] word_cnt;
    logic [15:0] len_q;
    logic        len_vld_q;
    logic [15:0] frm_cnt_q;
    logic [15:0] drop_cnt_q;

    logic        pop;
    logic [2:0]  used;
    logic        push;
    logic [3:0]  push_keep;
    logic        push_last;
    logic        push_user;
    logic        good_eop;
    logic        drop_inc;
    logic [15:0] eop_words;
    logic [15:0] word_cnt_nx;
    state_t      state_nx;

    function automatic logic [2:0] eop_bytes(input logic [1:0] ben);
        return (ben == 2'b00) ? 3'd4 : {1'b0, ben};
    endfunction

    function automatic logic [3:0] eop_keep(input logic [1:0] ben);
        case (ben)
            2'b01:   return 4'b0001;
            2'b10:   return 4'b0011;
            2'b11:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [15:0] calc_len(input logic [15:0] words, input logic [1:0] ben);
        return {words[13:0] - 14'd1, 2'b00} + 16'(eop_bytes(ben));
    endfunction

    // A beat being popped this cycle frees its slot for the request made now,
    // which keeps one word per cycle flowing when the sink never stalls.
    assign m_tvalid_o   = !mac_rst_i && (entries != 2'd0);
    assign pop          = m_tvalid_o && m_tready_i;
    assign used         = {1'b0, entries} + {2'b00, rd_pend_p0} - {2'b00, pop};
    assign mac_rxrqrd_o = !mac_rst_i && mac_rxda_i && (used < 3'd2);

    assign m_tdata_o  = m_tvalid_o ? data_mem[rd_ptr] : 32'd0;
    assign m_tkeep_o  = m_tvalid_o ? keep_mem[rd_ptr] : 4'd0;
    assign m_tlast_o  = m_tvalid_o && last_mem[rd_ptr];
    assign m_tuser_o  = m_tvalid_o && user_mem[rd_ptr];
    assign len_o      = mac_rst_i ? 16'd0 : len_q;
    assign len_vld_o  = !mac_rst_i && len_vld_q;
    assign frm_cnt_o  = mac_rst_i ? 16'd0 : frm_cnt_q;
    assign drop_cnt_o = mac_rst_i ? 16'd0 : drop_cnt_q;

    always_comb begin
        push        = 1'b0;
        push_keep   = 4'b1111;
        push_last   = 1'b0;
        push_user   = 1'b0;
        good_eop    = 1'b0;
        drop_inc    = 1'b0;
        eop_words   = word_cnt;
        word_cnt_nx = word_cnt;
        state_nx    = state;
        if (mac_rxdv_i) begin
            case (state)
                IDLE: begin
                    if (mac_rxsop_i) begin
                        push = 1'b1;
                        if (mac_rxeop_i) begin
                            push_last = 1'b1;
                            push_keep = eop_keep(mac_ben_i);
                            good_eop  = 1'b1;
                            eop_words = 16'd1;
                        end else begin
                            word_cnt_nx = 16'd1;
                            state_nx    = BODY;
                        end
                    end
                end
                BODY: begin
                    push = 1'b1;
                    // A new sop or a word past the limit closes the frame as an error beat.
                    if (mac_rxsop_i || (word_cnt == 16'(MAX_WORDS))) begin
                        push_keep = 4'b0000;
                        push_last = 1'b1;
                        push_user = 1'b1;
                        drop_inc  = 1'b1;
                        state_nx  = mac_rxeop_i ? IDLE : DROP;
                    end else if (mac_rxeop_i) begin
                        push_last = 1'b1;
                        push_keep = eop_keep(mac_ben_i);
                        good_eop  = 1'b1;
                        eop_words = word_cnt + 16'd1;
                        state_nx  = IDLE;
                    end else begin
                        word_cnt_nx = word_cnt + 16'd1;
                    end
                end
                DROP: begin
                    if (mac_rxeop_i) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            state      <= IDLE;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            entries    <= 2'd0;
            rd_pend_p0 <= 1'b0;
            word_cnt   <= 16'd0;
            len_q      <= 16'd0;
            len_vld_q  <= 1'b0;
            frm_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            state      <= state_nx;
            word_cnt   <= word_cnt_nx;
            rd_pend_p0 <= mac_rxrqrd_o;
            len_vld_q  <= good_eop;
            if (good_eop) begin
                len_q     <= calc_len(eop_words, mac_ben_i);
                frm_cnt_q <= frm_cnt_q + 16'd1;
            end
            if (drop_inc) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            entries <= entries + {1'b0, push} - {1'b0, pop};
        end
    end

    // Beat storage carries no reset; the output mux masks it while empty.
    always_ff @(posedge mac_clk_i) begin
        if (push && !mac_rst_i) begin
            data_mem[wr_ptr] <= mac_rxd_i;
            keep_mem[wr_ptr] <= push_keep;
            last_mem[wr_ptr] <= push_last;
            user_mem[wr_ptr] <= push_user;
        end
    end

endmodule

// File: tb/tb_mac_rx_read_ctrl.sv
// Bench for mac_rx_read_ctrl: a MAC FIFO model answers read requests a cycle
// later, accepted beats are logged, and frame-level vectors are checked.
module tb_mac_rx_read_ctrl;

    logic        clk = 1'b0;
    logic        mac_rst_i = 1'b1;
    logic [31:0] mac_rxd_i = '0;
    logic [1:0]  mac_ben_i = '0;
    logic        mac_rxda_i = 1'b0;
    logic        mac_rxsop_i = 1'b0;
    logic        mac_rxeop_i = 1'b0;
    logic        mac_rxdv_i = 1'b0;
    logic        mac_rxrqrd_o;
    logic [31:0] m_tdata_o;
    logic [3:0]  m_tkeep_o;
    logic        m_tvalid_o;
    logic        m_tlast_o;
    logic        m_tuser_o;
    logic        m_tready_i = 1'b0;
    logic [15:0] len_o;
    logic        len_vld_o;
    logic [15:0] frm_cnt_o;
    logic [15:0] drop_cnt_o;

    always #5 clk = ~clk;

    mac_rx_read_ctrl #(.MAX_WORDS(384)) dut (
        .mac_clk_i   (clk),
        .mac_rst_i   (mac_rst_i),
        .mac_rxd_i   (mac_rxd_i),
        .mac_ben_i   (mac_ben_i),
        .mac_rxda_i  (mac_rxda_i),
        .mac_rxsop_i (mac_rxsop_i),
        .mac_rxeop_i (mac_rxeop_i),
        .mac_rxdv_i  (mac_rxdv_i),
        .mac_rxrqrd_o(mac_rxrqrd_o),
        .m_tdata_o   (m_tdata_o),
        .m_tkeep_o   (m_tkeep_o),
        .m_tvalid_o  (m_tvalid_o),
        .m_tlast_o   (m_tlast_o),
        .m_tuser_o   (m_tuser_o),
        .m_tready_i  (m_tready_i),
        .len_o       (len_o),
        .len_vld_o   (len_vld_o),
        .frm_cnt_o   (frm_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  ben;
    } mword_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct {
        int          n;
        logic [1:0]  ben;
        int          mode;
        int          exp_beats;
        logic [3:0]  exp_keep;
        logic        exp_user;
        int          exp_lv;
        logic [15:0] exp_len;
        logic [15:0] exp_frm;
        logic [15:0] exp_drop;
        bit          chk_rate;
    } vec_t;

    mword_t mq[$];
    beat_t  bq[$];
    mword_t w;
    beat_t  hold_b;
    logic   hold_v = 1'b0;
    logic   rq_q = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     sent = 0;
    int     rq_cnt = 0;
    int     rq_first = -1;
    int     rq_last = -1;
    int     lv_cnt = 0;
    logic [15:0] lv_len = '0;
    int     tr_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_words(input int id, input int n, input logic [1:0] ben,
                              input bit s, input bit e);
        mword_t x;
        for (int i = 0; i < n; i++) begin
            x.d   = {id[15:0], i[15:0]};
            x.sop = s && (i == 0);
            x.eop = e && (i == n - 1);
            x.ben = ben;
            mq.push_back(x);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (mq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_log();
        bq.delete();
        lv_cnt   = 0;
        rq_cnt   = 0;
        rq_first = -1;
        rq_last  = -1;
        sent     = 0;
    endtask

    always @(posedge clk) rq_q <= mac_rxrqrd_o;

    // MAC FIFO model and output monitor.
    always @(negedge clk) begin
        cyc++;
        if (rq_q && mq.size() != 0) begin
            w = mq.pop_front();
            mac_rxd_i   = w.d;
            mac_rxsop_i = w.sop;
            mac_rxeop_i = w.eop;
            mac_ben_i   = w.ben;
            mac_rxdv_i  = 1'b1;
            sent++;
        end else begin
            mac_rxdv_i  = 1'b0;
            mac_rxsop_i = 1'b0;
            mac_rxeop_i = 1'b0;
        end
        mac_rxda_i = (mq.size() != 0);
        m_tready_i = (tr_mode == 0) || (tr_mode == 1 && (cyc % 2) == 1);
        #1;
        if (mac_rxrqrd_o) begin
            rq_cnt++;
            if (rq_first < 0) rq_first = cyc;
            rq_last = cyc;
        end
        if (mac_rst_i) begin
            chk("reset_outputs_zero",
                32'(|{mac_rxrqrd_o, m_tvalid_o, m_tlast_o, m_tuser_o, len_vld_o,
                      m_tdata_o, m_tkeep_o, len_o, frm_cnt_o, drop_cnt_o}), 32'd0);
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_hold_stable",
                    32'(m_tvalid_o && m_tdata_o == hold_b.d && m_tkeep_o == hold_b.k &&
                        m_tlast_o == hold_b.l && m_tuser_o == hold_b.u), 32'd1);
            end
            hold_v   = m_tvalid_o && !m_tready_i;
            hold_b.d = m_tdata_o;
            hold_b.k = m_tkeep_o;
            hold_b.l = m_tlast_o;
            hold_b.u = m_tuser_o;
            if (m_tvalid_o && m_tready_i) begin
                bq.push_back(hold_b);
            end
            if (len_vld_o) begin
                lv_cnt++;
                lv_len = len_o;
            end
        end
    end

    vec_t vt[6];

    initial begin
        logic [15:0] frm0, drop0;
        int bad, nb, n;

        //          n    ben    mode beats keep     user lv len     frm   drop  rate
        vt[0] = '{16,  2'b00, 0,  16,  4'b1111, 0,   1, 16'd64,   16'd1, 16'd0, 1};
        vt[1] = '{16,  2'b01, 1,  16,  4'b0001, 0,   1, 16'd61,   16'd1, 16'd0, 0};
        vt[2] = '{1,   2'b11, 0,  1,   4'b0111, 0,   1, 16'd3,    16'd1, 16'd0, 0};
        vt[3] = '{2,   2'b10, 1,  2,   4'b0011, 0,   1, 16'd6,    16'd1, 16'd0, 0};
        vt[4] = '{400, 2'b00, 0,  385, 4'b0000, 1,   0, 16'd0,    16'd0, 16'd1, 0};
        vt[5] = '{384, 2'b00, 0,  384, 4'b1111, 0,   1, 16'd1536, 16'd1, 16'd0, 0};

        repeat (3) @(negedge clk);
        mac_rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset_frm_cnt", 32'(frm_cnt_o), 32'd0);
        chk("post_reset_tvalid", 32'(m_tvalid_o), 32'd0);

        for (int k = 0; k < 6; k++) begin
            tr_mode = vt[k].mode;
            frm0  = frm_cnt_o;
            drop0 = drop_cnt_o;
            clear_log();
            push_words(k + 1, vt[k].n, vt[k].ben, 1'b1, 1'b1);
            wait_drain(vt[k].n * 4 + 50);
            chk($sformatf("v%0d_beats", k), 32'(bq.size()), 32'(vt[k].exp_beats));
            if (bq.size() != 0) begin
                chk($sformatf("v%0d_last_keep", k), 32'(bq[bq.size()-1].k), 32'(vt[k].exp_keep));
                chk($sformatf("v%0d_last_tlast", k), 32'(bq[bq.size()-1].l), 32'd1);
                chk($sformatf("v%0d_last_tuser", k), 32'(bq[bq.size()-1].u), 32'(vt[k].exp_user));
            end
            bad = 0;
            for (int i = 0; i < bq.size(); i++) begin
                if (bq[i].d !== {k[15:0] + 16'd1, i[15:0]}) bad++;
                if (i < bq.size() - 1 && (bq[i].k !== 4'b1111 || bq[i].l !== 1'b0)) bad++;
            end
            chk($sformatf("v%0d_sequence_errs", k), 32'(bad), 32'd0);
            chk($sformatf("v%0d_len_vld_cnt", k), 32'(lv_cnt), 32'(vt[k].exp_lv));
            if (vt[k].exp_lv != 0) begin
                chk($sformatf("v%0d_len", k), 32'(lv_len), 32'(vt[k].exp_len));
            end
            chk($sformatf("v%0d_frm_delta", k), 32'(frm_cnt_o - frm0), 32'(vt[k].exp_frm));
            chk($sformatf("v%0d_drop_delta", k), 32'(drop_cnt_o - drop0), 32'(vt[k].exp_drop));
            if (vt[k].chk_rate) begin
                chk($sformatf("v%0d_rq_cnt", k), 32'(rq_cnt), 32'd16);
                chk($sformatf("v%0d_rq_span", k), 32'(rq_last - rq_first), 32'd15);
            end
        end

        // sop arriving at word 5: frame closed with error, new frame dropped, next one clean
        tr_mode = 0;
        frm0  = frm_cnt_o;
        drop0 = drop_cnt_o;
        clear_log();
        push_words(10, 4, 2'b00, 1'b1, 1'b0);
        push_words(11, 6, 2'b00, 1'b1, 1'b1);
        push_words(12, 4, 2'b00, 1'b1, 1'b1);
        wait_drain(100);
        chk("sop_mid_beats", 32'(bq.size()), 32'd9);
        if (bq.size() == 9) begin
            chk("sop_mid_b3_tlast", 32'(bq[3].l), 32'd0);
            chk("sop_mid_err_beat", {bq[4].d[31:8], bq[4].k, bq[4].l, bq[4].u, 2'b00},
                {24'h000B00, 4'b0000, 1'b1, 1'b1, 2'b00});
            chk("sop_mid_next_data", bq[5].d, 32'h000C_0000);
            chk("sop_mid_next_last", {bq[8].d[31:1], bq[8].l}, {31'h0006_0001, 1'b1});
        end
        chk("sop_mid_drop_delta", 32'(drop_cnt_o - drop0), 32'd1);
        chk("sop_mid_frm_delta", 32'(frm_cnt_o - frm0), 32'd1);
        chk("sop_mid_len_vld_cnt", 32'(lv_cnt), 32'd1);
        chk("sop_mid_len", 32'(lv_len), 32'd16);

        // one-cycle reset at word 8 of a frame
        clear_log();
        push_words(20, 16, 2'b00, 1'b1, 1'b1);
        n = 0;
        while (sent < 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reset_wait_timeout", 32'(n < 200), 32'd1);
        mac_rst_i = 1'b1;
        @(negedge clk);
        mac_rst_i = 1'b0;
        nb = bq.size();
        wait_drain(100);
        chk("reset_no_beats_after", 32'(bq.size()), 32'(nb));
        chk("reset_frm_cnt_zero", 32'(frm_cnt_o), 32'd0);
        chk("reset_drop_cnt_zero", 32'(drop_cnt_o), 32'd0);
        clear_log();
        push_words(21, 4, 2'b10, 1'b1, 1'b1);
        wait_drain(100);
        chk("reset_next_frm_cnt", 32'(frm_cnt_o), 32'd1);
        chk("reset_next_beats", 32'(bq.size()), 32'd4);
        chk("reset_next_len", 32'(lv_len), 32'd14);

        // stray words in IDLE are discarded
        clear_log();
        push_words(30, 3, 2'b00, 1'b0, 1'b0);
        push_words(31, 2, 2'b10, 1'b1, 1'b1);
        wait_drain(100);
        chk("idle_discard_beats", 32'(bq.size()), 32'd2);
        if (bq.size() != 0) chk("idle_discard_first", bq[0].d, 32'h001F_0000);
        chk("idle_discard_frm_cnt", 32'(frm_cnt_o), 32'd2);
        chk("idle_discard_len", 32'(lv_len), 32'd6);

        // full stall with three single-word frames pending
        clear_log();
        tr_mode = 2;
        push_words(32, 1, 2'b11, 1'b1, 1'b1);
        push_words(33, 1, 2'b11, 1'b1, 1'b1);
        push_words(34, 1, 2'b11, 1'b1, 1'b1);
        repeat (15) @(negedge clk);
        chk("stall_no_accept", 32'(bq.size()), 32'd0);
        chk("stall_tvalid", 32'(m_tvalid_o), 32'd1);
        chk("stall_backpressure_left", 32'(mq.size()), 32'd1);
        tr_mode = 0;
        wait_drain(100);
        chk("stall_beats", 32'(bq.size()), 32'd3);
        if (bq.size() == 3) begin
            chk("stall_order0", bq[0].d, 32'h0020_0000);
            chk("stall_order2", bq[2].d, 32'h0022_0000);
            chk("stall_keep", 32'(bq[0].k), 32'h7);
        end
        chk("stall_len", 32'(lv_len), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
